mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) to single-RAM arbiter with a 3-state registered FSM; data side wins by default.
// Optional starvation guard for the instruction side enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ack,
  output logic [1:0]  arb_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IACC = 2'b01,
    DACC = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_dreq;
  logic   w_iack;
  logic   w_dack;
  logic   w_ipriority;

  assign w_dreq = dREN | dWEN;
  assign w_iack = (r_state == IACC) && iREN && ram_ack;
  assign w_dack = (r_state == DACC) && w_dreq && ram_ack;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);
  logic [7:0] r_starve;

  // Counts data completions that happened while an instruction fetch was waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve <= '0;
    end else if (!iREN || w_iack) begin
      r_starve <= '0;
    end else if (w_dack && (r_starve != 8'hFF)) begin
      r_starve <= r_starve + 8'd1;
    end
  end

  assign w_ipriority = iREN && (r_starve >= LIMIT_C);
`else
  assign w_ipriority = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_dreq && !w_ipriority) w_next = DACC;
        else if (iREN)              w_next = IACC;
      end
      IACC:    if (!iREN || ram_ack)   w_next = IDLE;
      DACC:    if (!w_dreq || ram_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Strobes follow the live request so a dropped request releases the RAM in the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = w_dreq;
    iload    = '0;
    dload    = '0;
    case (r_state)
      IACC: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
        end
        if (w_iack) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DACC: begin
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramaddr  = daddr;
          ramstore = dstore;
        end else if (dREN) begin
          ramREN  = 1'b1;
          ramaddr = daddr;
        end
        if (w_dack) begin
          dwait = 1'b0;
          if (!dWEN) dload = ramload;
        end
      end
      default: ;
    endcase
  end

  assign arb_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level owner model predicts every cycle's outputs,
// a separate monitor compares them at the falling edge. Directed scenarios followed by random traffic.
module tb_mem_arbiter;

  localparam int LIMIT = 4;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST, iREN, dREN, dWEN, ram_ack;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [1:0]  arb_state;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ack(ram_ack), .arb_state(arb_state)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int          cyc;
    logic [1:0]  st;
    logic        ren, wen;
    logic [31:0] addr, store;
    logic        iw;
    logic [31:0] il;
    logic        dw;
    logic [31:0] dl;
    logic        dl_care;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   ncyc = 0;
  bit   win = 1'b0;
  int   obs_iacc = 0;

  // Reference: who currently holds the RAM (0 nobody, 1 instruction, 2 data) and starvation tally.
  int owner = 0;
  int starve = 0;

  function automatic exp_t predict();
    exp_t e;
    e = '0;
    e.cyc = ncyc;
    e.iw = iREN;
    e.dw = dREN | dWEN;
    e.dl_care = 1'b1;
    if (nRST && owner == 1) begin
      e.st = 2'b01;
      if (iREN) begin
        e.ren = 1'b1;
        e.addr = iaddr;
        if (ram_ack) begin
          e.iw = 1'b0;
          e.il = ramload;
        end
      end
    end else if (nRST && owner == 2) begin
      e.st = 2'b10;
      if (dWEN) begin
        e.wen = 1'b1;
        e.addr = daddr;
        e.store = dstore;
        e.dl_care = !dREN;
      end else if (dREN) begin
        e.ren = 1'b1;
        e.addr = daddr;
      end
      if ((dREN | dWEN) && ram_ack) begin
        e.dw = 1'b0;
        if (dREN && !dWEN) e.dl = ramload;
      end
    end
    return e;
  endfunction

  function automatic void advance();
    bit dreq;
    dreq = dREN | dWEN;
    if (!nRST) begin
      owner = 0;
      starve = 0;
      return;
    end
    case (owner)
      0: begin
        if (dreq && !(FAIR && iREN && starve >= LIMIT)) owner = 2;
        else if (iREN) owner = 1;
      end
      1: begin
        if (iREN && ram_ack) starve = 0;
        if (!iREN || ram_ack) owner = 0;
      end
      default: begin
        if (dreq && ram_ack && iREN) starve = starve + 1;
        if (!dreq || ram_ack) owner = 0;
      end
    endcase
    if (!iREN) starve = 0;
  endfunction

  task automatic cyc(input logic rst, input logic ir, input logic dr, input logic dw,
                     input logic ack, input logic [31:0] ia, input logic [31:0] da,
                     input logic [31:0] ds, input logic [31:0] rl);
    @(posedge CLK);
    #1;
    nRST = rst; iREN = ir; dREN = dr; dWEN = dw; ram_ack = ack;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl;
    ncyc++;
    if (!rst) begin
      owner = 0;
      starve = 0;
    end
    q.push_back(predict());
    advance();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0BAD_F00D);
  endtask

  // Monitor: compares the presented outputs with the queued prediction for that cycle.
  initial begin : monitor
    exp_t e;
    logic [133:0] got, req;
    forever begin
      @(negedge CLK);
      if (win && arb_state == 2'b01) obs_iacc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {arb_state, ramREN, ramWEN, ramaddr, ramstore, iwait, iload, dwait,
               e.dl_care ? dload : 32'h0};
        req = {e.st, e.ren, e.wen, e.addr, e.store, e.iw, e.il, e.dw, e.dl};
        checks++;
        if (got !== req) begin
          failures++;
          $display("FAIL outputs cycle %0d: got %h expected %h", e.cyc, got, req);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int exp_iacc;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ack = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;

    // Reset with requests and ack active: strobes must stay low, waits follow requests.
    cyc(0, 1, 1, 1, 1, 32'h44, 32'h88, 32'h1234_5678, 32'hFFFF_FFFF);
    cyc(0, 1, 0, 1, 1, 32'h44, 32'h88, 32'h1234_5678, 32'hFFFF_FFFF);
    idle(2);

    // Single instruction fetch completing on the first strobe cycle.
    cyc(1, 1, 0, 0, 0, 32'h40, 0, 0, 32'h1111_1111);
    cyc(1, 1, 0, 0, 1, 32'h40, 0, 0, 32'h2008_0001);
    idle(2);

    // Simultaneous fetch and write: data first, ack on third strobe cycle, then fetch.
    cyc(1, 1, 0, 1, 0, 32'h40, 32'h100, 32'hDEAD_BEEF, 0);
    cyc(1, 1, 0, 1, 0, 32'h40, 32'h100, 32'hDEAD_BEEF, 0);
    cyc(1, 1, 0, 1, 0, 32'h40, 32'h100, 32'hDEAD_BEEF, 0);
    cyc(1, 1, 0, 1, 1, 32'h40, 32'h100, 32'hDEAD_BEEF, 32'h5555_AAAA);
    cyc(1, 1, 0, 0, 0, 32'h40, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 32'h40, 0, 0, 32'hCAFE_0001);
    idle(2);

    // Data read with a five-cycle ack delay.
    cyc(1, 0, 1, 0, 0, 0, 32'h200, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 1, 0, 0, 0, 32'h200, 0, 32'h7000_0000 + k);
    cyc(1, 0, 1, 0, 1, 0, 32'h200, 0, 32'hABCD_0123);
    idle(2);

    // Reset pulse in the middle of a write.
    cyc(1, 0, 0, 1, 0, 0, 32'h300, 32'h0F0F_0F0F, 0);
    cyc(1, 0, 0, 1, 0, 0, 32'h300, 32'h0F0F_0F0F, 0);
    cyc(0, 0, 0, 1, 1, 0, 32'h300, 32'h0F0F_0F0F, 32'h1);
    cyc(1, 0, 0, 1, 0, 0, 32'h300, 32'h0F0F_0F0F, 0);
    cyc(1, 0, 0, 1, 1, 0, 32'h300, 32'h0F0F_0F0F, 0);
    idle(2);

    // Data owner withdraws mid-access; the waiting fetch follows after one idle cycle.
    cyc(1, 1, 1, 0, 0, 32'h500, 32'h600, 0, 0);
    cyc(1, 1, 1, 0, 0, 32'h500, 32'h600, 0, 0);
    cyc(1, 1, 0, 0, 0, 32'h500, 32'h600, 0, 32'h9);
    cyc(1, 1, 0, 0, 0, 32'h500, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 32'h500, 0, 0, 32'h600D_600D);
    idle(2);

    // Saturated traffic on both sides with immediate acks.
    win = 1'b1;
    for (int k = 0; k < 40; k++) cyc(1, 1, 1, 0, 1, 32'h700 + k, 32'h800 + k, 0, $urandom);
    @(negedge CLK);
    #1;
    win = 1'b0;
    exp_iacc = FAIR ? 4 : 0;
    checks++;
    if (obs_iacc != exp_iacc) begin
      failures++;
      $display("FAIL starvation_iacc_cycles: got %0d expected %0d", obs_iacc, exp_iacc);
    end
    idle(2);

    // Random traffic, including dropped requests, read+write collisions and stray acks.
    for (int k = 0; k < 800; k++) begin
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          $urandom, $urandom, $urandom, $urandom);
    end
    idle(2);

    @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
